// File: rtl/bootram_loader_pkg.sv
// bootram_loader_pkg
// Shared types and helpers for the boot-RAM loader:
//   state_t        loader FSM encoding
//   SYNC_BYTE_DEF  default frame start marker
//   LEN_W          width of the frame length field
//   cap_of()       maximum payload length for a lane/address geometry
//   lane_of()      byte index -> lane select
//   addr_of()      byte index -> per-lane address
package bootram_loader_pkg;

    localparam int         LEN_W         = 16;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_CSUM,
        S_VERIFY,
        S_DONE,
        S_ERR
    } state_t;

    // One extra bit so the default geometry (8192) and larger ones still compare
    // correctly against a 16-bit length.
    function automatic logic [LEN_W:0] cap_of(input int num_lanes, input int addr_w);
        return (LEN_W+1)'(num_lanes << addr_w);
    endfunction

    function automatic logic [1:0] lane_of(input logic [LEN_W-1:0] idx, input int num_lanes);
        return idx[1:0] & 2'(num_lanes - 1);
    endfunction

    function automatic logic [LEN_W-1:0] addr_of(input logic [LEN_W-1:0] idx, input int num_lanes);
        case (num_lanes)
            4:       return idx >> 2;
            2:       return idx >> 1;
            default: return idx;
        endcase
    endfunction

endpackage

// File: rtl/bootram_lane_wr.sv
// bootram_lane_wr
// Registered access port into the byte-lane boot RAMs. A write or read strobe
// in one cycle becomes exactly one cycle of lane enable, address and data on
// the RAM pins in the next cycle.
// Ports:
//   clk, resetn        clock, async active-low reset
//   wr_stb, rd_stb     request a write / read of byte index idx
//   idx, data          byte index and write data
//   ram_ce             one-hot lane enable
//   ram_ad, ram_din    lane address and shared write data
//   ram_wre, ram_oce   write enable, output-register enable
module bootram_lane_wr
    import bootram_loader_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int NUM_LANES = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_stb,
    input  logic                 rd_stb,
    input  logic [LEN_W-1:0]     idx,
    input  logic [7:0]           data,
    output logic [NUM_LANES-1:0] ram_ce,
    output logic [ADDR_W-1:0]    ram_ad,
    output logic [7:0]           ram_din,
    output logic                 ram_wre,
    output logic                 ram_oce
);

    logic [1:0]           lane;
    logic [NUM_LANES-1:0] ce_sel;

    always_comb begin
        lane   = lane_of(idx, NUM_LANES);
        ce_sel = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            ce_sel[k] = (lane == 2'(k));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_ce  <= '0;
            ram_ad  <= '0;
            ram_din <= '0;
            ram_wre <= 1'b0;
            ram_oce <= 1'b0;
        end else begin
            ram_ce  <= (wr_stb || rd_stb) ? ce_sel : '0;
            ram_wre <= wr_stb;
            ram_oce <= rd_stb && !wr_stb;
            if (wr_stb || rd_stb) begin
                ram_ad <= ADDR_W'(addr_of(idx, NUM_LANES));
            end
            if (wr_stb) begin
                ram_din <= data;
            end
        end
    end

endmodule

// File: rtl/bootram_loader.sv
// bootram_loader
// Receives a framed byte stream (SYNC, LEN_H, LEN_L, payload, CSUM), writes the
// payload round-robin into the boot-RAM byte lanes, checks the 8-bit payload
// sum and releases the CPU from reset on success.
// Optional read-back verification of the loaded image: BOOTRAM_LOADER_VERIFY_EN.
// Ports:
//   clk, resetn             clock, async active-low reset
//   in_data/valid/ready     RX byte stream
//   ram_ce/wre/oce/reset    lane enables and controls
//   ram_ad/din/dout         lane address, write data, lane read data
//   cpu_resetn              CPU reset, released after a good load
//   load_ok/err, busy       status
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | hunting for SYNC_BYTE, other bytes dropped
// S_LEN_H  | waiting for length high byte
// S_LEN_L  | waiting for length low byte, range check
// S_DATA   | payload bytes, one RAM write each
// S_CSUM   | waiting for checksum byte
// S_VERIFY | reading image back and re-summing (optional)
// S_DONE   | CPU released, terminal until reset
// S_ERR    | bad frame, CPU held, hunting for SYNC_BYTE
module bootram_loader
    import bootram_loader_pkg::*;
#(
    parameter int         ADDR_W    = 11,
    parameter int         NUM_LANES = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NUM_LANES-1:0]   ram_ce,
    output logic                   ram_wre,
    output logic                   ram_oce,
    output logic                   ram_reset,
    output logic [ADDR_W-1:0]      ram_ad,
    output logic [7:0]             ram_din,
    input  logic [8*NUM_LANES-1:0] ram_dout,
    output logic                   cpu_resetn,
    output logic                   load_ok,
    output logic                   load_err,
    output logic                   busy
);

    localparam logic [LEN_W:0] CAP = cap_of(NUM_LANES, ADDR_W);

    state_t           state, state_nxt;
    logic [7:0]       len_h_q;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] rem_q;   // bytes (or reads) still to go
    logic [7:0]       sum_q;

    logic             acc;
    logic [LEN_W-1:0] len_w;
    logic             len_bad;
    logic             wr_stb;
    logic             rd_stb;

    assign acc     = in_valid && in_ready;
    assign len_w   = {len_h_q, in_data};
    assign len_bad = (len_w == '0) || ({1'b0, len_w} > CAP);
    assign wr_stb  = acc && (state == S_DATA);

`ifdef BOOTRAM_LOADER_VERIFY_EN
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] smp_rem;
    logic             rd_d1, rd_d2;
    logic [1:0]       lane_d1, lane_d2;
    logic [7:0]       rb_sum;
    logic [7:0]       rb_byte;
    logic             vfy_done, vfy_ok;

    assign rd_stb = (state == S_VERIFY) && (rem_q != '0);

    always_comb begin
        rb_byte = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_d2 == 2'(k)) begin
                rb_byte = ram_dout[8*k +: 8];
            end
        end
    end

    // Read data is valid two cycles after the read strobe: one for the
    // registered port, one for the RAM's own output register.
    assign vfy_done = rd_d2 && (smp_rem == LEN_W'(1));
    assign vfy_ok   = (8'(rb_sum + rb_byte) == sum_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_q   <= '0;
            smp_rem <= '0;
            rd_d1   <= 1'b0;
            rd_d2   <= 1'b0;
            lane_d1 <= '0;
            lane_d2 <= '0;
            rb_sum  <= '0;
        end else begin
            rd_d1   <= rd_stb;
            rd_d2   <= rd_d1;
            lane_d1 <= lane_of(idx_q, NUM_LANES);
            lane_d2 <= lane_d1;
            if (state == S_LEN_L && acc) begin
                len_q <= len_w;
            end
            if (state == S_CSUM && acc) begin
                smp_rem <= len_q;
                rb_sum  <= '0;
            end else if (rd_d2) begin
                smp_rem <= smp_rem - 1'b1;
                rb_sum  <= rb_sum + rb_byte;
            end
        end
    end
`else
    logic unused_dout;
    assign rd_stb      = 1'b0;
    assign unused_dout = ^ram_dout;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR: if (acc && in_data == SYNC_BYTE) state_nxt = S_LEN_H;
            S_LEN_H:       if (acc) state_nxt = S_LEN_L;
            S_LEN_L:       if (acc) state_nxt = len_bad ? S_ERR : S_DATA;
            S_DATA:        if (acc && rem_q == LEN_W'(1)) state_nxt = S_CSUM;
            S_CSUM: begin
                if (acc) begin
                    if (in_data != sum_q) begin
                        state_nxt = S_ERR;
                    end else begin
`ifdef BOOTRAM_LOADER_VERIFY_EN
                        state_nxt = S_VERIFY;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end
            end
`ifdef BOOTRAM_LOADER_VERIFY_EN
            S_VERIFY:      if (vfy_done) state_nxt = vfy_ok ? S_DONE : S_ERR;
`endif
            S_DONE:        state_nxt = S_DONE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_h_q <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            sum_q   <= '0;
        end else begin
            case (state)
                S_LEN_H: if (acc) len_h_q <= in_data;
                S_LEN_L: begin
                    if (acc) begin
                        rem_q <= len_w;
                        idx_q <= '0;
                        sum_q <= '0;
                    end
                end
                S_DATA: begin
                    if (acc) begin
                        idx_q <= idx_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        sum_q <= sum_q + in_data;
                    end
                end
`ifdef BOOTRAM_LOADER_VERIFY_EN
                S_CSUM: begin
                    if (acc) begin
                        idx_q <= '0;
                        rem_q <= len_q;
                    end
                end
                S_VERIFY: begin
                    if (rem_q != '0) begin
                        idx_q <= idx_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    bootram_lane_wr #(
        .ADDR_W    (ADDR_W),
        .NUM_LANES (NUM_LANES)
    ) u_lane_wr (
        .clk     (clk),
        .resetn  (resetn),
        .wr_stb  (wr_stb),
        .rd_stb  (rd_stb),
        .idx     (idx_q),
        .data    (in_data),
        .ram_ce  (ram_ce),
        .ram_ad  (ram_ad),
        .ram_din (ram_din),
        .ram_wre (ram_wre),
        .ram_oce (ram_oce)
    );

    assign in_ready   = !(state == S_DONE || state == S_VERIFY);
    assign busy       = (state == S_LEN_H) || (state == S_LEN_L) || (state == S_DATA) ||
                        (state == S_CSUM)  || (state == S_VERIFY);
    assign cpu_resetn = (state == S_DONE);
    assign load_ok    = (state == S_DONE);
    assign load_err   = (state == S_ERR);
    assign ram_reset  = 1'b0;

endmodule
